// File: rtl/full_adder.sv
// Ripple-carry adder of identical 1-bit cells, {carry_out, sum} = a + b + carry_in (0 cycles),
// plus a 1-cycle registered copy captured on in_valid; no backpressure, accepts every cycle.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             out_valid
);

    logic [WIDTH:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic prop;

        assign prop         = a[i] ^ b[i];
        assign sum[i]       = prop ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & prop);
    end

    assign carry_out = carry[WIDTH];

    // Reset wins over in_valid so a result captured alongside reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid   <= 1'b0;
        end else if (in_valid) begin
            sum_q       <= sum;
            carry_out_q <= carry_out;
            out_valid   <= 1'b1;
        end else begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH = 1, 4 and 8.
module tb_full_adder;

    logic clk;
    logic reset;

    logic       a1, b1, c1, v1;
    logic       s1, co1, sq1, coq1, ov1;
    logic [3:0] a4, b4, s4, sq4;
    logic       c4, v4, co4, coq4, ov4;
    logic [7:0] a8, b8, s8, sq8;
    logic       c8, v8, co8, coq8, ov8;

    int n_vec = 0;
    int n_err = 0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1), .carry_in(c1), .in_valid(v1),
        .sum(s1), .carry_out(co1), .sum_q(sq1), .carry_out_q(coq1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .carry_in(c4), .in_valid(v4),
        .sum(s4), .carry_out(co4), .sum_q(sq4), .carry_out_q(coq4), .out_valid(ov4)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .carry_in(c8), .in_valid(v8),
        .sum(s8), .carry_out(co8), .sum_q(sq8), .carry_out_q(coq8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_tab [8];
    logic [2:0] vec;
    logic [8:0] exp9;
    logic [8:0] held8;
    logic       prev_v8;

    initial begin
        exp_tab = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        reset = 1'b1;
        {a1, b1, c1, v1} = '0;
        {a4, b4, c4, v4} = '0;
        {a8, b8, c8, v8} = '0;

        // WIDTH=1 exhaustive truth table, combinational only
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {a1, b1, c1} = vec;
            #30;
            chk($sformatf("w1_comb_%0d", i), {62'd0, s1, co1}, {62'd0, exp_tab[i]});
        end

        // Reset held for two edges
        step();
        step();
        reset = 1'b0;
        chk("w1_rst_sum_q", {63'd0, sq1}, 64'd0);
        chk("w1_rst_cout_q", {63'd0, coq1}, 64'd0);
        chk("w1_rst_valid", {63'd0, ov1}, 64'd0);
        chk("w4_rst_sum_q", {60'd0, sq4}, 64'd0);
        chk("w8_rst_valid", {63'd0, ov8}, 64'd0);

        // WIDTH=1 registered capture then hold
        {a1, b1, c1, v1} = 4'b1111;
        step();
        v1 = 1'b0;
        chk("w1_reg_sum_q", {63'd0, sq1}, 64'd1);
        chk("w1_reg_cout_q", {63'd0, coq1}, 64'd1);
        chk("w1_reg_valid", {63'd0, ov1}, 64'd1);
        {a1, b1, c1} = 3'b000;
        step();
        chk("w1_idle_valid", {63'd0, ov1}, 64'd0);
        chk("w1_hold_sum_q", {63'd0, sq1}, 64'd1);
        chk("w1_hold_cout_q", {63'd0, coq1}, 64'd1);

        // WIDTH=4 full-width ripple and mixed pattern
        a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
        #1;
        chk("w4_ripple", {59'd0, co4, s4}, {59'd0, 5'h10});
        a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
        #1;
        chk("w4_7p8", {59'd0, co4, s4}, {59'd0, 5'h0F});

        // WIDTH=4 max case, combinational then registered
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; v4 = 1'b1;
        #1;
        chk("w4_max_comb", {59'd0, co4, s4}, {59'd0, 5'h1F});
        step();
        v4 = 1'b0;
        chk("w4_max_reg", {59'd0, coq4, sq4}, {59'd0, 5'h1F});
        chk("w4_max_valid", {63'd0, ov4}, 64'd1);

        // Reset beats in_valid on the same edge
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        reset = 1'b1;
        #1;
        chk("rstpri_comb_before", {63'd0, s1}, 64'd1);
        step();
        chk("rstpri_sum_q", {63'd0, sq1}, 64'd0);
        chk("rstpri_valid", {63'd0, ov1}, 64'd0);
        chk("rstpri_comb_after", {63'd0, s1}, 64'd1);
        reset = 1'b0;
        v1 = 1'b0;

        // WIDTH=8 random regression with a held-value model
        held8 = '0;
        prev_v8 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            v8 = 1'($urandom_range(0, 1));
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            #1;
            chk($sformatf("w8_comb_%0d", i), {55'd0, co8, s8}, {55'd0, exp9});
            if (v8) held8 = exp9;
            prev_v8 = v8;
            step();
            chk($sformatf("w8_reg_%0d", i), {55'd0, coq8, sq8}, {55'd0, held8});
            chk($sformatf("w8_valid_%0d", i), {63'd0, ov8}, {63'd0, prev_v8});
        end
        v8 = 1'b0;
        step();
        chk("w8_final_idle", {63'd0, ov8}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Combinational full adder (sum/carry of A + B + carry-in) with an optional registered copy of the result for pipelined datapaths.
- Default instance is the 1-bit cell. WIDTH > 1 builds a ripple-carry chain of identical 1-bit cells.
- The combinational outputs are the primary interface. The registered outputs serve clocked consumers.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..32).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- in_valid  input  1  qualifies a/b/carry_in for capture into the output register.
- sum  output  WIDTH  combinational sum.
- carry_out  output  1  combinational carry out of MSB.
- sum_q  output  WIDTH  registered sum.
- carry_out_q  output  1  registered carry_out.
- out_valid  output  1  registered in_valid.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Per-bit cell, for i = 0..WIDTH-1:
  - s[i] = a[i] XOR b[i] XOR c[i]
  - c[i+1] = (a[i] AND b[i]) OR (c[i] AND (a[i] XOR b[i]))
  - c[0] = carry_in
- Output mapping: sum = s; carry_out = c[WIDTH]. Equivalently {carry_out, sum} = a + b + carry_in, unsigned, WIDTH+1 bits, no truncation.
- Combinational path:
  - Zero cycles of latency.
  - Independent of clk, reset and in_valid.
  - Settles within one propagation delay of any input change.
  - No latches.
- Registered path, on rising clk edge:
  - reset=1: sum_q <= 0, carry_out_q <= 0, out_valid <= 0. Reset has priority over in_valid.
  - else if in_valid=1: sum_q <= sum, carry_out_q <= carry_out, out_valid <= 1.
  - else: sum_q and carry_out_q hold their values; out_valid <= 0.
- Registered-path latency is 1 cycle from in_valid sampled high.
- Back-to-back valid inputs give back-to-back results; there is no backpressure.
- Reset mid-operation: a result captured on the same edge that reset is high is discarded. out_valid is 0 the following cycle.
- Before the first clock edge with reset applied, the registered outputs are undefined. The combinational outputs are always defined for defined inputs.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, carry_out = 1.
  - All-zeros + all-zeros + 0 gives sum = 0, carry_out = 0.
  - Carry ripples the full width: a = all-ones, b = 0, carry_in = 1 gives sum = 0, carry_out = 1.
- X/Z on any input bit may propagate to the dependent outputs. No X-masking is required.

Test Plan:
- WIDTH=1, exhaustive combinational check. Apply (A,B,Cin) = 000, 001, 010, 011, 100, 101, 110, 111, holding each for 30 time units. Required (sum,carry_out): 00, 10, 10, 01, 10, 01, 01, 11.
- WIDTH=1, registered path. Hold reset for 2 cycles, then check sum_q=0, carry_out_q=0, out_valid=0. Drive 1,1,1 with in_valid=1 for one cycle. Next cycle: sum_q=1, carry_out_q=1, out_valid=1. Following cycle with in_valid=0: out_valid=0, sum_q=1 held.
- WIDTH=4, ripple check. a=4'hF, b=4'h0, carry_in=1 gives sum=4'h0, carry_out=1. a=4'h7, b=4'h8, carry_in=0 gives sum=4'hF, carry_out=0.
- WIDTH=4, max case. a=4'hF, b=4'hF, carry_in=1 gives sum=4'hF, carry_out=1 on both the combinational and the registered outputs (registered one cycle later).
- Reset priority. Assert reset and in_valid together with a=1, b=0, carry_in=0. Next cycle: sum_q=0, out_valid=0, while combinational sum=1 throughout.
- Random regression, WIDTH=8. 1000 random a, b, carry_in values. Check {carry_out,sum} == a+b+carry_in combinationally, and the registered outputs match the previous cycle's valid input.
